// File: rtl/mc_main_fsm.sv
// mc_main_fsm: main control sequencer for the multicycle MIPS datapath,
// with a wait-state handshake on the shared memory port.
module mc_main_fsm #(
    parameter int MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    state_t     st;
    logic       rdy;
    logic       rtype_ok;
    logic       op_ok;
    logic       is_bne;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic       illegal_s;
    logic [1:0] aluop;

    // With wait states disabled every memory access completes in one cycle.
    assign rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    assign rtype_ok = (funct == F_ADD) || (funct == F_SUB) ||
                      (funct == F_AND) || (funct == F_OR)  ||
                      (funct == F_SLT);

    assign op_ok = (op == OP_LW)   || (op == OP_SW)   ||
                   (op == OP_BEQ)  || (op == OP_BNE)  ||
                   (op == OP_ADDI) || (op == OP_J)    ||
                   ((op == OP_RTYPE) && rtype_ok);

    assign is_bne = (op == OP_BNE);

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= FETCH;
        end else begin
            case (st)
                FETCH: begin
                    if (rdy)
                        st <= DECODE;
                end
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW:    st <= MEMADR;
                        OP_RTYPE:        st <= rtype_ok ? EXECUTE : FETCH;
                        OP_BEQ, OP_BNE:  st <= BRANCH;
                        OP_ADDI:         st <= ADDIEX;
                        OP_J:            st <= JUMP;
                        default:         st <= FETCH;
                    endcase
                end
                MEMADR:  st <= (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD: begin
                    if (rdy)
                        st <= MEMWB;
                end
                MEMWB:   st <= FETCH;
                MEMWR: begin
                    if (rdy)
                        st <= FETCH;
                end
                EXECUTE: st <= ALUWB;
                ALUWB:   st <= FETCH;
                BRANCH:  st <= FETCH;
                ADDIEX:  st <= ADDIWB;
                ADDIWB:  st <= FETCH;
                JUMP:    st <= FETCH;
                default: st <= FETCH;
            endcase
        end
    end

    always_comb begin
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        illegal_s  = 1'b0;
        case (st)
            FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = rdy;
                pcwrite   = rdy;
            end
            DECODE: begin
                alusrcb   = 2'b11;
                illegal_s = ~op_ok;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    F_SUB:   alucontrol = 3'b110;
                    F_AND:   alucontrol = 3'b000;
                    F_OR:    alucontrol = 3'b001;
                    F_SLT:   alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Architectural strobes are suppressed for the whole reset cycle.
    assign pcen       = ~reset & (pcwrite | (branch & (zero ^ is_bne)));
    assign irwrite    = ~reset & irwrite_s;
    assign memwrite   = ~reset & memwrite_s;
    assign regwrite   = ~reset & regwrite_s;
    assign illegal_op = ~reset & illegal_s;
    assign state      = st;

endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: randomized bench for mc_main_fsm against an
// instruction-level model of the control sequence.
module tb_mc_main_fsm;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       memwrite, irwrite, pcen, iord, alusrca, regdst;
    logic       memtoreg, regwrite, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic       n_memwrite, n_irwrite, n_pcen, n_iord, n_alusrca, n_regdst;
    logic       n_memtoreg, n_regwrite, n_illegal_op;
    logic [1:0] n_alusrcb, n_pcsrc;
    logic [2:0] n_alucontrol;
    logic [3:0] n_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_main_fsm #(.MEM_WAIT_EN(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memwrite(memwrite), .irwrite(irwrite),
        .pcen(pcen), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op),
        .state(state)
    );

    mc_main_fsm #(.MEM_WAIT_EN(0)) dut_nw (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memwrite(n_memwrite), .irwrite(n_irwrite),
        .pcen(n_pcen), .iord(n_iord), .alusrca(n_alusrca),
        .alusrcb(n_alusrcb), .regdst(n_regdst), .memtoreg(n_memtoreg),
        .regwrite(n_regwrite), .pcsrc(n_pcsrc), .alucontrol(n_alucontrol),
        .illegal_op(n_illegal_op), .state(n_state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcen;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       iord;
        logic       ill;
        logic       regdst;
        logic       memtoreg;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] alu;
    } obs_t;

    obs_t expq[$];
    logic mrq[$];

    function automatic obs_t mk(input logic [3:0] s);
        obs_t e;
        e = '0;
        e.st = s;
        e.alu = 3'b010;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state;
        o.pcen = pcen;
        o.irw = irwrite;
        o.mw = memwrite;
        o.rw = regwrite;
        o.iord = iord;
        o.ill = illegal_op;
        o.regdst = regdst;
        o.memtoreg = memtoreg;
        o.srca = alusrca;
        o.srcb = alusrcb;
        o.pcsrc = pcsrc;
        o.alu = alucontrol;
        return o;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
               f == 6'b100101 || f == 6'b101010;
    endfunction

    function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
        return o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_BNE ||
               o == OP_ADDI || o == OP_J || (o == OP_RTYPE && funct_ok(f));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input obs_t e, input logic mr);
        expq.push_back(e);
        mrq.push_back(mr);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, fetch included.
    task automatic model_instr(input logic [5:0] o, input logic [5:0] f,
                               input logic z, input int fw, input int mw);
        obs_t e;
        for (int i = 0; i < fw; i++) begin
            e = mk(4'd0); e.srcb = 2'b01;
            push(e, 1'b0);
        end
        e = mk(4'd0); e.srcb = 2'b01; e.pcen = 1'b1; e.irw = 1'b1;
        push(e, 1'b1);
        e = mk(4'd1); e.srcb = 2'b11; e.ill = !legal(o, f);
        push(e, rbit());
        if (!legal(o, f))
            return;
        case (o)
            OP_LW: begin
                e = mk(4'd2); e.srca = 1'b1; e.srcb = 2'b10;
                push(e, rbit());
                e = mk(4'd3); e.iord = 1'b1;
                for (int i = 0; i < mw; i++)
                    push(e, 1'b0);
                push(e, 1'b1);
                e = mk(4'd4); e.rw = 1'b1; e.memtoreg = 1'b1;
                push(e, rbit());
            end
            OP_SW: begin
                e = mk(4'd2); e.srca = 1'b1; e.srcb = 2'b10;
                push(e, rbit());
                e = mk(4'd5); e.iord = 1'b1; e.mw = 1'b1;
                for (int i = 0; i < mw; i++)
                    push(e, 1'b0);
                push(e, 1'b1);
            end
            OP_RTYPE: begin
                e = mk(4'd6); e.srca = 1'b1; e.alu = alu_ref(f);
                push(e, rbit());
                e = mk(4'd7); e.rw = 1'b1; e.regdst = 1'b1;
                push(e, rbit());
            end
            OP_ADDI: begin
                e = mk(4'd9); e.srca = 1'b1; e.srcb = 2'b10;
                push(e, rbit());
                e = mk(4'd10); e.rw = 1'b1;
                push(e, rbit());
            end
            OP_BEQ, OP_BNE: begin
                e = mk(4'd8); e.srca = 1'b1; e.alu = 3'b110;
                e.pcsrc = 2'b01; e.pcen = z ^ (o == OP_BNE);
                push(e, rbit());
            end
            default: begin
                e = mk(4'd11); e.pcsrc = 2'b10; e.pcen = 1'b1;
                push(e, rbit());
            end
        endcase
    endtask

    task automatic play(input string name, input logic [5:0] o,
                        input logic [5:0] f, input logic z);
        obs_t got;
        for (int i = 0; i < expq.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                op = o;
                funct = f;
                zero = z;
            end
            mem_ready = mrq[i];
            #1;
            got = sample();
            checks++;
            if (got !== expq[i]) begin
                failures++;
                $display("FAIL %s cycle %0d: got %h expected %h",
                         name, i, got, expq[i]);
            end
        end
        expq.delete();
        mrq.delete();
    endtask

    task automatic run(input string name, input logic [5:0] o,
                       input logic [5:0] f, input logic z,
                       input int fw, input int mw);
        model_instr(o, f, z, fw, mw);
        play(name, o, f, z);
    endtask

    task automatic test_reset();
        op = OP_J;
        repeat (2) begin
            @(negedge clk);
            mem_ready = rbit();
            #1;
            checks++;
            if ({pcen, irwrite, memwrite, regwrite, illegal_op} !== 5'b0) begin
                failures++;
                $display("FAIL reset_strobes: got %b expected 00000",
                         {pcen, irwrite, memwrite, regwrite, illegal_op});
            end
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, pcen, irwrite} !== {4'd0, 2'b11}) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h",
                     {state, pcen, irwrite}, {4'd0, 2'b11});
        end
        @(negedge clk);
        mem_ready = rbit();
        #1;
        checks++;
        if ({state, illegal_op} !== {4'd1, 1'b0}) begin
            failures++;
            $display("FAIL reset_decode: got %h expected %h",
                     {state, illegal_op}, {4'd1, 1'b0});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({state, pcen, pcsrc} !== {4'd11, 1'b1, 2'b10}) begin
            failures++;
            $display("FAIL reset_jump: got %h expected %h",
                     {state, pcen, pcsrc}, {4'd11, 1'b1, 2'b10});
        end
    endtask

    task automatic test_lw();
        run("lw", OP_LW, 6'($urandom), 1'b0, 0, 0);
        run("lw_wait", OP_LW, 6'($urandom), 1'b1, 2, 2);
    endtask

    task automatic test_sw_wait();
        run("sw_wait", OP_SW, 6'($urandom), 1'b0, 0, 3);
    endtask

    task automatic test_rtype();
        run("slt", OP_RTYPE, 6'b101010, 1'b0, 0, 0);
        run("bad_funct", OP_RTYPE, 6'b000111, 1'b0, 0, 0);
        run("sub", OP_RTYPE, 6'b100010, 1'b1, 1, 0);
    endtask

    task automatic test_branch();
        run("beq_taken", OP_BEQ, 6'd0, 1'b1, 0, 0);
        run("beq_not", OP_BEQ, 6'd0, 1'b0, 0, 0);
        run("bne_taken", OP_BNE, 6'd0, 1'b0, 0, 0);
        run("bne_not", OP_BNE, 6'd0, 1'b1, 0, 0);
    endtask

    task automatic test_illegal_op();
        run("op_3f", 6'b111111, 6'd0, 1'b0, 0, 0);
        run("addi_after", OP_ADDI, 6'd0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        obs_t e;
        e = mk(4'd0); e.srcb = 2'b01; e.pcen = 1'b1; e.irw = 1'b1;
        push(e, 1'b1);
        e = mk(4'd1); e.srcb = 2'b11;
        push(e, rbit());
        e = mk(4'd2); e.srca = 1'b1; e.srcb = 2'b10;
        push(e, rbit());
        e = mk(4'd3); e.iord = 1'b1;
        push(e, 1'b0);
        push(e, 1'b0);
        play("rst_mid_pre", OP_LW, 6'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, regwrite, memwrite, pcen, irwrite} !== {4'd3, 4'b0}) begin
            failures++;
            $display("FAIL rst_mid_hold: got %h expected %h",
                     {state, regwrite, memwrite, pcen, irwrite}, {4'd3, 4'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, regwrite, memwrite, irwrite} !== {4'd0, 3'b0}) begin
            failures++;
            $display("FAIL rst_mid_after: got %h expected %h",
                     {state, regwrite, memwrite, irwrite}, {4'd0, 3'b0});
        end
    endtask

    task automatic test_random();
        logic [5:0] o, f;
        for (int n = 0; n < 40; n++) begin
            f = 6'($urandom);
            case ($urandom_range(0, 8))
                0: o = OP_LW;
                1: o = OP_SW;
                2: begin
                    o = OP_RTYPE;
                    case ($urandom_range(0, 4))
                        0: f = 6'b100000;
                        1: f = 6'b100010;
                        2: f = 6'b100100;
                        3: f = 6'b100101;
                        default: f = 6'b101010;
                    endcase
                end
                3: begin
                    o = OP_RTYPE;
                    while (funct_ok(f))
                        f = 6'($urandom);
                end
                4: o = OP_BEQ;
                5: o = OP_BNE;
                6: o = OP_ADDI;
                7: o = OP_J;
                default: begin
                    o = 6'($urandom);
                    while (legal(o, f) || o == OP_RTYPE)
                        o = 6'($urandom);
                end
            endcase
            run("random", o, f, rbit(), $urandom_range(0, 2),
                $urandom_range(0, 3));
        end
    endtask

    task automatic test_nowait();
        logic [3:0] seq [5];
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op = OP_LW;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, n_state, n_irwrite, n_pcen} !== {8'd0, 2'b11}) begin
            failures++;
            $display("FAIL nowait_fetch: got %h expected %h",
                     {state, n_state, n_irwrite, n_pcen}, {8'd0, 2'b11});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({state, n_state} !== {4'd0, seq[i]}) begin
                failures++;
                $display("FAIL nowait_seq %0d: got %h expected %h",
                         i, {state, n_state}, {4'd0, seq[i]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_branch();
        test_illegal_op();
        test_reset_mid();
        test_random();
        test_nowait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
